// File: rtl/pwm_dac_pkg.sv
// Shared types and constants for the PWM audio DAC.
// The PWM_DAC_DITHER_EN build option uses the LFSR seed/tap constants defined here.
package pwm_dac_pkg;

    localparam int          M_DEFAULT = 12;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        RAMP = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int midscale(input int m);
        return 1 << (m - 1);
    endfunction

endpackage

// File: rtl/pwm_dac_lfsr.sv
// 16-bit Galois LFSR; advances one step per cycle with step=1.
// It is instantiated by pwm_dac only when PWM_DAC_DITHER_EN is defined.
module pwm_dac_lfsr
    import pwm_dac_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (step) q_d = (q_q >> 1) ^ (q_q[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= LFSR_SEED;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/pwm_dac.sv
// PWM audio DAC: one sample per 2^M-clock period, with a soft-start duty ramp to midscale.
// With PWM_DAC_DITHER_EN defined, RUN duty gets 1-LSB LFSR dither, saturating at full scale.
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int M         = M_DEFAULT,
    parameter int RAMP_STEP = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [M-1:0] wave,
    input  logic         mute,
    output logic         sample_req,
    output logic         pwm_out,
    output logic         ramping
);

    localparam logic [M-1:0] MID  = M'(midscale(M));
    localparam logic [M-1:0] MAXV = '1;
    // The step is clamped to midscale so that duty + step always fits in M+1 bits.
    localparam logic [M:0]   STEP = (RAMP_STEP >= midscale(M)) ? {1'b0, MID} : (M+1)'(RAMP_STEP);

    state_e       state_q, state_d;
    logic [M-1:0] cnt_q, cnt_d;
    logic [M-1:0] duty_q, duty_d;
    logic         pwm_q, pwm_d;
    logic         wrap;
    logic [M:0]   ramp_sum;
    logic [M-1:0] run_duty;

    assign wrap     = ena && (cnt_q == MAXV);
    assign ramp_sum = {1'b0, duty_q} + STEP;

`ifdef PWM_DAC_DITHER_EN
    logic [15:0] lfsr_q;
    logic        lfsr_step;
    logic [M:0]  dith_sum;

    assign lfsr_step = wrap && (state_q == RUN);
    assign dith_sum  = {1'b0, wave} + {{M{1'b0}}, lfsr_q[0]};
    assign run_duty  = dith_sum[M] ? MAXV : dith_sum[M-1:0];

    pwm_dac_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );
`else
    assign run_duty = wave;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        pwm_d   = 1'b0;
        if (ena) begin
            cnt_d = cnt_q + M'(1);
            pwm_d = (cnt_q < duty_q);
            if (wrap) begin
                unique case (state_q)
                    RAMP: begin
                        if (ramp_sum >= {1'b0, MID}) begin
                            duty_d  = MID;
                            state_d = RUN;
                        end else begin
                            duty_d = ramp_sum[M-1:0];
                        end
                    end
                    RUN:     duty_d = mute ? MID : run_duty;
                    default: state_d = RAMP;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RAMP;
            cnt_q   <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
        end
    end

    assign sample_req = wrap;
    assign pwm_out    = pwm_q;
    assign ramping    = (state_q == RAMP);

endmodule
